// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared widths, PC command encoding and bubble word for the fetch sequencer.
package pc_ctrl_pkg;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 14;
  localparam int STACK_DEPTH = 8;
  typedef enum logic [2:0] {
    PC_INC  = 3'd0,
    PC_SKIP = 3'd1,
    PC_GOTO = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4,
    PC_BRA  = 3'd5
  } pc_op_e;
  localparam logic [DATA_W-1:0] NOP_INSTR = 14'h0000;
endpackage

// File: rtl/return_stack.sv
// return_stack: circular hardware return-address stack with sticky overflow/underflow flags.
module return_stack #(
  parameter int ADDR_W = pc_ctrl_pkg::ADDR_W,
  parameter int STACK_DEPTH = pc_ctrl_pkg::STACK_DEPTH,
  localparam int SW = $clog2(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic [SW-1:0]     sp,
  output logic              ovf,
  output logic              unf
);
  localparam logic [SW:0] FULL = (SW+1)'(STACK_DEPTH);
  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [SW:0] count;
  logic [SW-1:0] sp_m1;
  assign sp_m1 = sp - SW'(1);
  // An empty pop still reads the wrapped slot below sp; only the flag records the fault.
  assign pop_data = mem[sp_m1];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
      sp <= '0;
      count <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (push) begin
      mem[sp] <= push_data;
      sp <= sp + SW'(1);
      count <= (count == FULL) ? count : count + (SW+1)'(1);
      ovf <= ovf | (count == FULL);
    end else if (pop) begin
      sp <= sp_m1;
      count <= (count == '0) ? count : count - (SW+1)'(1);
      unf <= unf | (count == '0);
    end
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and two-stage fetch/IR pipeline driving a combinational ROM.
module pc_fetch_ctrl #(
  parameter int ADDR_W = pc_ctrl_pkg::ADDR_W,
  parameter int DATA_W = pc_ctrl_pkg::DATA_W,
  parameter int STACK_DEPTH = pc_ctrl_pkg::STACK_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           stall,
  input  logic [2:0]                     pc_op,
  input  logic [ADDR_W-1:0]              target,
  input  logic [8:0]                     offset,
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [DATA_W-1:0]              rom_data,
  output logic [DATA_W-1:0]              ir,
  output logic                           ir_valid,
  output logic [ADDR_W-1:0]              ir_pc,
  output logic [$clog2(STACK_DEPTH)-1:0] stack_ptr,
  output logic                           stack_ovf,
  output logic                           stack_unf
);
  import pc_ctrl_pkg::*;
  logic [ADDR_W-1:0] pc_fetch, next_pc, pop_data;
  logic [2:0] op;
  logic flush, push, pop;
  assign rom_addr = pc_fetch;
  // A bubble in IR carries no instruction, so its decoder command is ignored.
  always_comb begin
    op = ir_valid ? pc_op : PC_INC;
    flush = (op != PC_INC) && (op <= PC_BRA);
    push = !stall && (op == PC_CALL);
    pop = !stall && (op == PC_RET);
    next_pc = (op == PC_GOTO || op == PC_CALL) ? target :
              (op == PC_RET) ? pop_data :
              (op == PC_BRA) ? pc_fetch + ADDR_W'($signed(offset)) :
              pc_fetch + ADDR_W'(1);
  end
  return_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .push_data(pc_fetch),
    .pop_data(pop_data),
    .sp(stack_ptr),
    .ovf(stack_ovf),
    .unf(stack_unf)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_fetch <= '0;
      ir <= NOP_INSTR;
      ir_valid <= 1'b0;
      ir_pc <= '0;
    end else if (!stall) begin
      ir_pc <= pc_fetch;
      pc_fetch <= next_pc;
      ir <= flush ? NOP_INSTR : rom_data;
      ir_valid <= !flush;
    end
  end
endmodule
